// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC register controls, fetches from program
// memory over req/ack, and presents each fetched word to decode over valid/ready.
module instr_fetch_sequencer #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [AW-1:0] pc_q,
    output logic          pc_hold,
    output logic          pc_increment,
    output logic          pc_load,
    output logic [AW-1:0] pc_d,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_pc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [1:0]    dbg_state
);

    // Handshakes: mem_req stays high (address stable) until the cycle mem_ack is seen;
    // an instruction is consumed in a cycle with instr_valid & instr_ready & !redirect.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] fetch_addr;
    logic          capture;
    logic          redir;

    assign dbg_state = state;

    always_comb begin
        state_nxt    = state;
        pc_increment = 1'b0;
        pc_load      = 1'b0;
        pc_d         = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        instr_valid  = 1'b0;
        capture      = 1'b0;
        redir        = redirect && (state != IDLE);

        if (redir) begin
            pc_load = 1'b1;
            pc_d    = redirect_addr;
        end

        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (redir) begin
                    state_nxt = mem_ack ? FETCH : DRAIN;
                end else if (mem_ack) begin
                    capture      = 1'b1;
                    pc_increment = 1'b1;
                    state_nxt    = OUT;
                end
            end
            OUT: begin
                instr_valid = 1'b1;
                if (redir || instr_ready) state_nxt = FETCH;
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = fetch_addr;
                // Once the stale request completes there is nothing left to drain, even if
                // another redirect lands now; the PC load already carries the newest target.
                if (mem_ack) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase

        pc_hold = !(pc_increment || pc_load);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
            instr_data <= '0;
            instr_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) fetch_addr <= pc_q;
            if (capture) begin
                instr_data <= mem_rdata;
                instr_pc   <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: PC register and variable-latency memory models,
// directed scenarios plus randomized ready/redirect traffic, queue-based scoreboard.
module tb_instr_fetch_sequencer;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [AW-1:0] pc_q;
    logic          pc_hold, pc_increment, pc_load;
    logic [AW-1:0] pc_d;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [1:0]    dbg_state;

    instr_fetch_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .run(run), .pc_q(pc_q),
        .pc_hold(pc_hold), .pc_increment(pc_increment), .pc_load(pc_load), .pc_d(pc_d),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_addr(redirect_addr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]    mem [0:(1<<AW)-1];
    logic [AW+DW-1:0] exp_q[$];
    bit   running   = 0;
    bit   force_ack = 0;
    int   lat_fixed = -1;
    int   inc_cnt = 0, vrise_cnt = 0, accept_cnt = 0;
    logic valid_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // PC register model: load beats increment, wraps naturally at AW bits
    always @(posedge clk or posedge reset) begin
        if (reset)             pc_q <= '0;
        else if (pc_load)      pc_q <= pc_d;
        else if (pc_increment) pc_q <= pc_q + 1'b1;
    end

    // Memory responder: latency 0..4 cycles per request, checks address stability
    int            wait_left = 0;
    bit            in_req    = 0;
    logic [AW-1:0] req_addr  = '0;
    always @(posedge clk) begin
        #2;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = DW'($urandom);
            in_req    = 0;
        end else if (reset) begin
            mem_ack = 1'b0;
            in_req  = 0;
        end else if (mem_req) begin
            if (!in_req) begin
                in_req    = 1;
                req_addr  = mem_addr;
                wait_left = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 4);
            end else begin
                check("mem_addr_stable", 32'(mem_addr), 32'(req_addr));
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                in_req    = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = DW'($urandom);
                wait_left--;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = DW'($urandom);
            in_req    = 0;
        end
    end

    // Monitor / scoreboard
    logic [AW+DW-1:0] mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            check("pc_hold", 32'(pc_hold), 32'(!(pc_increment || pc_load)));
            check("inc_load_exclusive", 32'(pc_increment && pc_load), 32'd0);
            if (running && redirect) begin
                check("redir_pc_load", 32'(pc_load), 32'd1);
                check("redir_pc_d", 32'(pc_d), 32'(redirect_addr));
                check("redir_no_inc", 32'(pc_increment), 32'd0);
            end else begin
                check("no_spurious_load", 32'(pc_load), 32'd0);
            end
            if (pc_increment) begin
                inc_cnt++;
                check("inc_needs_ack", 32'(mem_req && mem_ack), 32'd1);
            end
            if (instr_valid && !valid_d) vrise_cnt++;
            valid_d = instr_valid;
            if (instr_valid && instr_ready && !redirect) begin
                accept_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr actual_pc=%0h expected=none", instr_pc);
                end else begin
                    checks--;
                    mon_e = exp_q.pop_front();
                    check("instr_pc", 32'(instr_pc), 32'(mon_e[AW+DW-1:DW]));
                    check("instr_data", 32'(instr_data), 32'(mon_e[DW-1:0]));
                end
            end
        end
    end

    task automatic push_from(input logic [AW-1:0] start);
        logic [AW-1:0] a;
        exp_q.delete();
        for (int i = 0; i < 200; i++) begin
            a = start + AW'(i);
            exp_q.push_back({a, mem[a]});
        end
    endtask

    // Called at posedge+1; leaves at the next posedge+1
    task automatic do_redirect(input logic [AW-1:0] target);
        redirect      = 1'b1;
        redirect_addr = target;
        push_from(target);
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    task automatic wait_accept();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid && instr_ready && !redirect) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_accept_timeout actual=none expected=accept");
        end
    endtask

    task automatic wait_valid();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_valid_timeout actual=none expected=instr_valid");
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_pc_hold", 32'(pc_hold), 32'd1);
        check("rst_pc_increment", 32'(pc_increment), 32'd0);
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_pc_d", 32'(pc_d), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_data", 32'(instr_data), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
    endtask

    task automatic start_run();
        push_from('0);
        run = 1'b1;
        @(posedge clk); #1;
        run     = 1'b0;
        running = 1;
    endtask

    int a0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[0] = 16'hA5A5;
        reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;

        // redirect while idle is ignored (monitor flags any pc_load)
        redirect = 1'b1; redirect_addr = 12'h555;
        @(posedge clk); #1 redirect = 1'b0;
        @(negedge clk);
        check("idle_no_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;

        // basic fetch, latency 1, decode ready
        lat_fixed = 1; instr_ready = 1'b1;
        start_run();
        repeat (4) wait_accept();

        // decode stalls 5 cycles: output stable, no request, PC held
        @(posedge clk); #1 instr_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", 32'(instr_pc), 32'(exp_q[0][AW+DW-1:DW]));
            check("stall_data", 32'(instr_data), 32'(exp_q[0][DW-1:0]));
            check("stall_no_req", 32'(mem_req), 32'd0);
            check("stall_pc_hold", 32'(pc_hold), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1 instr_ready = 1'b1;

        // throughput: zero-wait memory, decode always ready -> 1 per 2 cycles
        lat_fixed = 0;
        repeat (6) @(posedge clk);
        a0 = accept_cnt;
        repeat (20) @(posedge clk);
        check("throughput", 32'(accept_cnt - a0), 32'd10);

        // redirect in OUT with ready high: instruction dropped, valid low next cycle
        @(posedge clk); #1 instr_ready = 1'b0;
        wait_valid();
        @(posedge clk); #1 instr_ready = 1'b1;
        do_redirect(12'h3F0);
        @(negedge clk);
        check("redir_out_valid_drop", 32'(instr_valid), 32'd0);
        wait_accept();

        // redirect during FETCH, late ack is drained; then double redirect in DRAIN
        lat_fixed = 3;
        wait_accept();
        @(posedge clk); #1 do_redirect(12'h100);
        wait_accept();
        wait_accept();
        @(posedge clk); #1 do_redirect(12'h200);
        do_redirect(12'h300);
        wait_accept();

        // wrap-around with mixed latencies
        lat_fixed = 0;
        wait_accept();
        @(posedge clk); #1 do_redirect(12'hFFF);
        repeat (2) wait_accept();
        lat_fixed = 4;
        wait_accept();
        @(posedge clk); #1 do_redirect(12'hFFE);
        repeat (3) wait_accept();

        // randomized traffic
        lat_fixed = -1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            instr_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) begin
                redirect      = 1'b1;
                redirect_addr = AW'($urandom);
                push_from(redirect_addr);
            end else begin
                redirect = 1'b0;
            end
        end
        @(posedge clk); #1 redirect = 1'b0; instr_ready = 1'b1;
        wait_accept();

        // reset while draining, stale ack arrives afterwards
        lat_fixed = 4;
        wait_accept();
        @(posedge clk); #1 do_redirect(12'h0AB);
        reset = 1'b1; force_ack = 1'b1; running = 0;
        @(negedge clk) check_reset_outputs();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("late_ack_seen", 32'(mem_ack), 32'd1);
        check("late_ack_no_valid", 32'(instr_valid), 32'd0);
        check("late_ack_no_inc", 32'(pc_increment), 32'd0);
        check("late_ack_no_load", 32'(pc_load), 32'd0);
        check("late_ack_no_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1 force_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_idle_valid", 32'(instr_valid), 32'd0);
            check("post_reset_idle_req", 32'(mem_req), 32'd0);
        end

        check("one_inc_per_fetch", 32'(inc_cnt), 32'(vrise_cnt));
        checks++;
        if (accept_cnt < 20) begin
            errors++;
            $display("FAIL accept_count actual=%0d expected>=20", accept_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
